spike_conditioner: RTL and testbench

SPIKE_CONDITIONER -- requirements
Module: spike_conditioner

---
 rtl/spike_conditioner.sv | 137 +++++++++++++
 tb/tb_spike_conditioner.sv | 330 +++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/spike_conditioner.sv
// Spike conditioner: per-channel sync, edge detect, refractory, round-robin.
// Optional drop counter enabled by defining SPIKE_COND_DROP_CNT_EN.
module spike_conditioner #(
  parameter int p_refract_cyc = 4,
  parameter int p_sync_stages = 2
) (
  input  logic        i_clk_tst,
  input  logic        i_rst_n,
  input  logic [4:1]  i_spike_raw,
  input  logic        i_enable,
  output logic [4:1]  o_spike,
  output logic        o_spike_valid,
`ifdef SPIKE_COND_DROP_CNT_EN
  output logic [15:0] o_drop_count,
`endif
  output logic        o_busy
);

  localparam logic [3:0] LP_REFR = 4'(p_refract_cyc);
  localparam int LP_LAST = p_sync_stages - 1;

  logic [3:0] r_sync [p_sync_stages];
  logic [3:0] r_hist;
  logic [3:0] r_pend;
  logic [3:0] r_spike;
  logic [3:0] r_refr [4];
  logic       r_valid;
  logic       r_busy;
  logic [1:0] r_last;

  logic [3:0] w_edge;
  logic [3:0] w_zero;
  logic [3:0] w_acc;
  logic [3:0] w_grant;
  logic [3:0] w_pend_nxt;
  logic [1:0] w_gidx;
  logic [1:0] w_idx;
  logic       w_found;

  always_comb begin
    w_zero = '0;
    for (int i = 0; i < 4; i++) begin
      w_zero[i] = (r_refr[i] == 4'd0);
    end
  end

  assign w_edge = r_sync[LP_LAST] & ~r_hist;
  assign w_acc  = w_edge & w_zero & {4{i_enable}};

  // Search starts one past the last grant; 2-bit index wraps ch4 -> ch1.
  always_comb begin
    w_grant = '0;
    w_gidx  = r_last;
    w_idx   = r_last;
    w_found = 1'b0;
    for (int k = 1; k <= 4; k++) begin
      w_idx = r_last + 2'(k);
      if (!w_found && r_pend[w_idx]) begin
        w_found        = 1'b1;
        w_gidx         = w_idx;
        w_grant[w_idx] = 1'b1;
      end
    end
  end

  assign w_pend_nxt = i_enable ? ((r_pend & ~w_grant) | w_acc) : 4'd0;

  always_ff @(posedge i_clk_tst or negedge i_rst_n) begin
    if (!i_rst_n) begin
      for (int s = 0; s < p_sync_stages; s++) begin
        r_sync[s] <= '0;
      end
      for (int i = 0; i < 4; i++) begin
        r_refr[i] <= '0;
      end
      r_hist  <= '0;
      r_pend  <= '0;
      r_spike <= '0;
      r_valid <= 1'b0;
      r_busy  <= 1'b0;
      r_last  <= 2'd3;
    end else begin
      r_sync[0] <= i_spike_raw;
      for (int s = 1; s < p_sync_stages; s++) begin
        r_sync[s] <= r_sync[s-1];
      end
      r_hist  <= r_sync[LP_LAST];
      r_pend  <= w_pend_nxt;
      r_spike <= w_grant;
      r_valid <= w_found;
      r_busy  <= |w_pend_nxt;
      if (w_found) begin
        r_last <= w_gidx;
      end
      for (int i = 0; i < 4; i++) begin
        if (w_acc[i]) begin
          r_refr[i] <= LP_REFR;
        end else if (!w_zero[i]) begin
          r_refr[i] <= r_refr[i] - 4'd1;
        end
      end
    end
  end

  assign o_spike       = r_spike;
  assign o_spike_valid = r_valid;
  assign o_busy        = r_busy;

`ifdef SPIKE_COND_DROP_CNT_EN
  logic [3:0]  w_drop;
  logic [2:0]  w_ndrop;
  logic [16:0] w_dsum;
  logic [15:0] r_drop;

  assign w_drop = w_acc & r_pend & ~w_grant;

  always_comb begin
    w_ndrop = '0;
    for (int i = 0; i < 4; i++) begin
      w_ndrop = w_ndrop + 3'(w_drop[i]);
    end
  end

  assign w_dsum = {1'b0, r_drop} + 17'(w_ndrop);

  always_ff @(posedge i_clk_tst or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_drop <= '0;
    end else begin
      r_drop <= w_dsum[16] ? 16'hFFFF : w_dsum[15:0];
    end
  end

  assign o_drop_count = r_drop;
`endif

endmodule

// File: tb/tb_spike_conditioner.sv
// Bench for spike_conditioner: expected pulses queued at stimulus time,
// matched by a negedge monitor; per-scenario tasks add cycle-exact checks.
module tb_spike_conditioner;

  localparam int P_REFR = 4;

  logic       clk;
  logic       rst_n;
  logic [4:1] raw;
  logic [4:1] raw1;
  logic       en;
  logic [4:1] spike;
  logic       valid;
  logic       busy;
  logic [4:1] spike1;
  logic       valid1;
  logic       busy1;
`ifdef SPIKE_COND_DROP_CNT_EN
  logic [15:0] drops;
  logic [15:0] drops1;
`endif

  int n_chk = 0;
  int n_err = 0;
  int r1_pulses = 0;
  logic [3:0] q_exp [$];

  spike_conditioner #(
    .p_refract_cyc(P_REFR),
    .p_sync_stages(2)
  ) u_dut (
    .i_clk_tst    (clk),
    .i_rst_n      (rst_n),
    .i_spike_raw  (raw),
    .i_enable     (en),
    .o_spike      (spike),
    .o_spike_valid(valid),
`ifdef SPIKE_COND_DROP_CNT_EN
    .o_drop_count (drops),
`endif
    .o_busy       (busy)
  );

  spike_conditioner #(
    .p_refract_cyc(1),
    .p_sync_stages(2)
  ) u_dut_r1 (
    .i_clk_tst    (clk),
    .i_rst_n      (rst_n),
    .i_spike_raw  (raw1),
    .i_enable     (en),
    .o_spike      (spike1),
    .o_spike_valid(valid1),
`ifdef SPIKE_COND_DROP_CNT_EN
    .o_drop_count (drops1),
`endif
    .o_busy       (busy1)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(negedge clk) begin
    if (spike != 4'd0 || valid) begin
      n_chk++;
      if (q_exp.size() == 0) begin
        n_err++;
        $display("FAIL unexpected_pulse got=%b", spike);
      end else begin
        logic [3:0] e;
        e = q_exp.pop_front();
        if (spike !== e) begin
          n_err++;
          $display("FAIL pulse_order got=%b exp=%b", spike, e);
        end
      end
      n_chk++;
      if (valid !== (|spike)) begin
        n_err++;
        $display("FAIL valid_or got=%b exp=%b", valid, |spike);
      end
    end
  end

  always @(negedge clk) begin
    if (spike1 != 4'd0) begin
      r1_pulses++;
      n_chk++;
      if (!$onehot(spike1)) begin
        n_err++;
        $display("FAIL r1_onehot got=%b exp=onehot", spike1);
      end
    end
  end

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) @(negedge clk);
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst_n = 1'b0;
    idle(2);
    rst_n = 1'b1;
  endtask

  task automatic chk_q_empty(input string nm);
    n_chk++;
    if (q_exp.size() != 0) begin
      n_err++;
      $display("FAIL %s_missing got=%0d exp=0", nm, q_exp.size());
      q_exp.delete();
    end
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    raw   = '0;
    raw1  = '0;
    en    = 1'b1;
    #1;
    n_chk++;
    if (spike !== 4'd0) begin
      n_err++;
      $display("FAIL rst_spike got=%b exp=0000", spike);
    end
    n_chk++;
    if (valid !== 1'b0 || busy !== 1'b0) begin
      n_err++;
      $display("FAIL rst_flags got=%b%b exp=00", valid, busy);
    end
`ifdef SPIKE_COND_DROP_CNT_EN
    n_chk++;
    if (drops !== 16'd0) begin
      n_err++;
      $display("FAIL rst_drops got=%0d exp=0", drops);
    end
`endif
    idle(3);
    rst_n = 1'b1;
    idle(3);
  endtask

  task automatic test_single();
    logic [3:0] e;
    @(negedge clk);
    raw = 4'b0010;
    q_exp.push_back(4'b0010);
    for (int c = 1; c <= 7; c++) begin
      @(posedge clk);
      #1;
      if (c == 2) raw = '0;
      e = (c == 4) ? 4'b0010 : 4'b0000;
      n_chk++;
      if (spike !== e) begin
        n_err++;
        $display("FAIL single_c%0d got=%b exp=%b", c, spike, e);
      end
      n_chk++;
      if (busy !== (c == 3)) begin
        n_err++;
        $display("FAIL single_busy_c%0d got=%b exp=%b", c, busy, c == 3);
      end
    end
    idle(10);
    chk_q_empty("single");
  endtask

  task automatic test_all_rise();
    logic exp_v;
    do_reset();
    raw = 4'b1111;
    for (int c = 0; c < 4; c++) q_exp.push_back(4'(1 << c));
    for (int c = 1; c <= 9; c++) begin
      @(posedge clk);
      #1;
      exp_v = (c >= 4 && c <= 7);
      n_chk++;
      if (valid !== exp_v) begin
        n_err++;
        $display("FAIL allrise_v_c%0d got=%b exp=%b", c, valid, exp_v);
      end
    end
    raw = '0;
    idle(10);
    chk_q_empty("allrise");
  endtask

  task automatic test_refract();
    int last_acc;
    last_acc = -100;
    for (int k = 0; k < 6; k++) begin
      if (4 * k - last_acc >= P_REFR + 1) begin
        q_exp.push_back(4'b0001);
        last_acc = 4 * k;
      end
    end
    for (int cyc = 0; cyc < 24; cyc++) begin
      @(negedge clk);
      raw = {3'b000, (cyc % 4) < 2};
    end
    raw = '0;
    idle(12);
    chk_q_empty("refract");
`ifdef SPIKE_COND_DROP_CNT_EN
    n_chk++;
    if (drops !== 16'd0) begin
      n_err++;
      $display("FAIL refract_drops got=%0d exp=0", drops);
    end
`endif
  endtask

  task automatic test_enable_drop();
    logic [3:0] e;
    do_reset();
    raw = 4'b0111;
    q_exp.push_back(4'b0001);
    for (int c = 1; c <= 12; c++) begin
      @(posedge clk);
      #1;
      if (c == 3) begin
        n_chk++;
        if (busy !== 1'b1) begin
          n_err++;
          $display("FAIL endrop_busy3 got=%b exp=1", busy);
        end
        en = 1'b0;
      end
      if (c == 7) en = 1'b1;
      if (c >= 4) begin
        e = (c == 4) ? 4'b0001 : 4'b0000;
        n_chk++;
        if (spike !== e || busy !== 1'b0) begin
          n_err++;
          $display("FAIL endrop_c%0d got=%b/%b exp=%b/0", c, spike, busy, e);
        end
      end
    end
    raw = '0;
    idle(10);
    chk_q_empty("endrop");
  endtask

  task automatic test_reset_mid();
    logic [3:0] e;
    do_reset();
    raw = 4'b1111;
    q_exp.push_back(4'b0001);
    for (int c = 1; c <= 5; c++) begin
      @(posedge clk);
      #1;
    end
    n_chk++;
    if (spike !== 4'b0010) begin
      n_err++;
      $display("FAIL rstmid_pre got=%b exp=0010", spike);
    end
    raw = 4'b1001;
    #1;
    rst_n = 1'b0;
    #1;
    n_chk++;
    if (spike !== 4'd0 || valid !== 1'b0 || busy !== 1'b0) begin
      n_err++;
      $display("FAIL rstmid_async got=%b%b%b exp=000000", spike, valid, busy);
    end
    idle(2);
    rst_n = 1'b1;
    q_exp.push_back(4'b0001);
    q_exp.push_back(4'b1000);
    for (int c = 1; c <= 8; c++) begin
      @(posedge clk);
      #1;
      e = (c == 4) ? 4'b0001 : (c == 5) ? 4'b1000 : 4'b0000;
      n_chk++;
      if (spike !== e) begin
        n_err++;
        $display("FAIL rstmid_c%0d got=%b exp=%b", c, spike, e);
      end
    end
    raw = '0;
    idle(10);
    chk_q_empty("rstmid");
  endtask

  task automatic test_drops();
    int base;
    int acc;
    base = r1_pulses;
    acc  = 0;
    for (int cyc = 0; cyc < 16; cyc++) begin
      @(negedge clk);
      raw1 = (cyc % 2 == 0) ? 4'hF : 4'h0;
      if (cyc % 2 == 0) acc += 4;
    end
    raw1 = '0;
    idle(20);
    n_chk++;
    if (busy1 !== 1'b0) begin
      n_err++;
      $display("FAIL drops_busy got=%b exp=0", busy1);
    end
    n_chk++;
    if (r1_pulses - base >= acc || r1_pulses - base == 0) begin
      n_err++;
      $display("FAIL drops_pulses got=%0d exp=1..%0d", r1_pulses - base, acc - 1);
    end
`ifdef SPIKE_COND_DROP_CNT_EN
    n_chk++;
    if (int'(drops1) !== acc - (r1_pulses - base)) begin
      n_err++;
      $display("FAIL drops_count got=%0d exp=%0d", drops1, acc - (r1_pulses - base));
    end
`endif
  endtask

  initial begin
    test_reset();
    test_single();
    test_all_rise();
    test_refract();
    test_enable_drop();
    test_reset_mid();
    test_drops();
    $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
    $finish;
  end

endmodule
